seg7_scan_ctrl: RTL

//   Time-multiplexed driver for the board's 8-digit common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for an 8-digit common-anode
// 7-segment display, with a blanking gap before every digit.
//
// Ports:
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   enable_i             1 = scan, 0 = display dark
//   value_i              32-bit hex value, nibble k drives digit k
//   value_valid_i        value_i is valid
//   value_ready_o        pending slot free (transfer on valid & ready)
//   dp_mask_i            bit k lights the decimal point of digit k
//   blank_mask_i         bit k keeps digit k dark
//   anode                digit selects, active-low
//   cathode              segments {g,f,e,d,c,b,a}, active-low
//   dp                   decimal point, active-low
//   frame_done_o         1-cycle pulse after digit 7's slot ends
module seg7_scan_ctrl #(
    parameter int DIGIT_CYCLES = 12500,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable_i,
    input  logic [31:0] value_i,
    input  logic        value_valid_i,
    output logic        value_ready_o,
    input  logic [7:0]  dp_mask_i,
    input  logic [7:0]  blank_mask_i,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_done_o
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;

    logic [31:0]   active_q, active_d;
    logic [31:0]   pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic          ready_q, ready_d;

    logic [7:0]    anode_q, anode_d;
    logic [6:0]    cathode_q, cathode_d;
    logic          dp_q, dp_d;
    logic          fdone_q, fdone_d;

    logic          frame_end;
    logic          capture;
    logic          commit;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Scan sequencing: the slot counter runs 0..DIGIT_CYCLES-1 and the
    // state is BLANK for the first BLANK_CYCLES counts, SHOW for the rest.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        frame_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable_i) begin
                    state_d = BLANK;
                end
            end
            BLANK, SHOW: begin
                frame_end = (state_q == SHOW) &&
                            (idx_q == 3'd7) &&
                            (cnt_q == CNT_LAST);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = (cnt_d < CNT_BLANK) ? BLANK : SHOW;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        if (!enable_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            idx_d     = '0;
            frame_end = 1'b0;
        end
    end

    // One-deep pending buffer. The active value only changes at a frame
    // boundary (or immediately when the display is off) so a frame never
    // mixes two values. Capture needs an empty buffer, so it can never
    // coincide with a commit.
    always_comb begin
        capture    = value_valid_i && ready_q;
        commit     = pend_q && (frame_end || !enable_i);
        active_d   = active_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        if (commit) begin
            active_d = pend_val_q;
            pend_d   = 1'b0;
        end
        if (capture) begin
            pend_val_d = value_i;
            pend_d     = 1'b1;
        end
        ready_d = ~pend_d;
    end

    // Pin values are derived from the next state so the registered
    // pins line up with the state register.
    always_comb begin
        nibble    = active_q[4*idx_d +: 4];
        anode_d   = 8'hFF;
        cathode_d = 7'h7F;
        dp_d      = 1'b1;
        fdone_d   = frame_end;
        if (state_d == SHOW) begin
            cathode_d = hex7(nibble);
            dp_d      = ~dp_mask_i[idx_d];
            if (!blank_mask_i[idx_d]) begin
                anode_d = ~(8'b1 << idx_d);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            active_q   <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b1;
            anode_q    <= 8'hFF;
            cathode_q  <= 7'h7F;
            dp_q       <= 1'b1;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
            dp_q       <= dp_d;
            fdone_q    <= fdone_d;
        end
    end

    assign value_ready_o = ready_q;
    assign anode         = anode_q;
    assign cathode       = cathode_q;
    assign dp            = dp_q;
    assign frame_done_o  = fdone_q;

endmodule
